// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - iterative signed/unsigned restoring divider with pipeline stall sequencing
// Holds the pipeline while dividing, then presents registered results for one Done cycle.
module div_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero,
   output logic             Done,
   output logic             DivStall
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t           state;
   logic             signed_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] diff;

   always_comb begin
      dvd_mag = dvd_q;
      dvs_mag = dvs_q;
      if (signed_q && dvd_q[WIDTH-1]) dvd_mag = -dvd_q;
      if (signed_q && dvs_q[WIDTH-1]) dvs_mag = -dvs_q;
      shifted = {rem, quo[WIDTH-1]};
      fits    = shifted >= {1'b0, dvs_q};
      // When the divisor fits, the difference is below 2^WIDTH, so the low bits are exact.
      diff    = shifted[WIDTH-1:0] - dvs_q;
   end

   assign DivStall = (state == PREP) || (state == CALC) || (state == FIX) ||
                     ((state == IDLE) && start);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         signed_q  <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         count     <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  signed_q <= Signed;
                  dvd_q    <= Dividend;
                  dvs_q    <= Divisor;
                  state    <= PREP;
               end
            end
            PREP: begin
               if (dvs_q == '0) begin
                  Quotient  <= '1;
                  Remainder <= dvd_q;
                  DivByZero <= 1'b1;
                  Done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  // From here on dvs_q holds the divisor magnitude.
                  quo   <= dvd_mag;
                  dvs_q <= dvs_mag;
                  neg_q <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                  neg_r <= signed_q & dvd_q[WIDTH-1];
                  rem   <= '0;
                  count <= CW'(WIDTH - 1);
                  state <= CALC;
               end
            end
            CALC: begin
               if (fits) begin
                  rem <= diff;
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               count <= count - 1'b1;
               if (count == '0) state <= FIX;
            end
            FIX: begin
               Quotient  <= neg_q ? -quo : quo;
               Remainder <= neg_r ? -rem : rem;
               DivByZero <= 1'b0;
               Done      <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               Done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
